wb_mem_router: RTL and testbench

Registered Wishbone-classic router between the Grande_Risco5 core's single master port and the two memory ports of the Controller: the unified core port and the optional second (data) memory port. It decodes each core request by address and forwards it to exactly one downstream port. It returns the response with a one-cycle ack pulse. A watchdog guarantees the core never hangs on a missing ack.

---
 rtl/wb_mem_router.sv | 197 +++++++++++++++++++
 tb/tb_wb_mem_router.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_router.sv
// wb_mem_router: registered Wishbone-classic router from one core master port
// to two downstream memory ports, with address decode, one-cycle response
// pulse, abort handling and a watchdog that turns a missing ack into an error.
module wb_mem_router #(
  parameter int unsigned            ADDR_WIDTH     = 32,
  parameter int unsigned            DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0]  DATA_MEM_BASE  = 32'h8000_0000,
  parameter logic [ADDR_WIDTH-1:0]  DATA_MEM_MASK  = 32'h8000_0000,
  parameter int unsigned            TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  // core request / response
  input  logic                    s_cyc_i,
  input  logic                    s_stb_i,
  input  logic                    s_we_i,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb_i,
  input  logic [ADDR_WIDTH-1:0]   s_addr_i,
  input  logic [DATA_WIDTH-1:0]   s_data_i,
  output logic [DATA_WIDTH-1:0]   s_data_o,
  output logic                    s_ack_o,
  output logic                    s_err_o,
  // port 0: unified core memory port
  output logic                    m0_cyc_o,
  output logic                    m0_stb_o,
  output logic                    m0_we_o,
  output logic [DATA_WIDTH/8-1:0] m0_wstrb_o,
  output logic [ADDR_WIDTH-1:0]   m0_addr_o,
  output logic [DATA_WIDTH-1:0]   m0_data_o,
  input  logic [DATA_WIDTH-1:0]   m0_data_i,
  input  logic                    m0_ack_i,
  // port 1: data memory port
  output logic                    m1_cyc_o,
  output logic                    m1_stb_o,
  output logic                    m1_we_o,
  output logic [DATA_WIDTH/8-1:0] m1_wstrb_o,
  output logic [ADDR_WIDTH-1:0]   m1_addr_o,
  output logic [DATA_WIDTH-1:0]   m1_data_o,
  input  logic [DATA_WIDTH-1:0]   m1_data_i,
  input  logic                    m1_ack_i,
  // watchdog statistics
  output logic [15:0]             timeout_count_o
);

  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 32'd1);
  localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        sel_q;      // 1 = transaction routed to port 1
  logic [31:0] wait_cnt;   // cycles spent in REQ for the current transaction
  logic        dec_sel;
  logic        sel_ack;
  logic        accept;
  logic        abort;
  logic        ack_hit;
  logic        expire;
  logic        leave;

  // address decode of the incoming request and ack of the routed port only
  always_comb begin
    dec_sel = ((s_addr_i & DATA_MEM_MASK) == DATA_MEM_BASE);
    sel_ack = sel_q ? m1_ack_i : m0_ack_i;
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state and transaction events; in REQ an ack beats a simultaneous
  // watchdog expiry, and a dropped s_cyc_i ends the transaction silently
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    abort   = 1'b0;
    ack_hit = 1'b0;
    expire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_cyc_i && s_stb_i) begin
          accept  = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (!s_cyc_i) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (sel_ack) begin
          ack_hit = 1'b1;
          state_d = RESP;
        end else if (WD_EN && (wait_cnt == WD_LAST)) begin
          expire  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    leave = abort | ack_hit | expire;
  end

  // port 0 request registers; they double as the request latch, so the
  // unselected port keeps its previous payload untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_cyc_o   <= 1'b0;
      m0_stb_o   <= 1'b0;
      m0_we_o    <= 1'b0;
      m0_wstrb_o <= '0;
      m0_addr_o  <= '0;
      m0_data_o  <= '0;
    end else if (accept && !dec_sel) begin
      m0_cyc_o   <= 1'b1;
      m0_stb_o   <= 1'b1;
      m0_we_o    <= s_we_i;
      m0_wstrb_o <= s_wstrb_i;
      m0_addr_o  <= s_addr_i;
      m0_data_o  <= s_data_i;
    end else if (leave) begin
      m0_cyc_o   <= 1'b0;
      m0_stb_o   <= 1'b0;
    end
  end

  // port 1 request registers, same scheme as port 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m1_cyc_o   <= 1'b0;
      m1_stb_o   <= 1'b0;
      m1_we_o    <= 1'b0;
      m1_wstrb_o <= '0;
      m1_addr_o  <= '0;
      m1_data_o  <= '0;
    end else if (accept && dec_sel) begin
      m1_cyc_o   <= 1'b1;
      m1_stb_o   <= 1'b1;
      m1_we_o    <= s_we_i;
      m1_wstrb_o <= s_wstrb_i;
      m1_addr_o  <= s_addr_i;
      m1_data_o  <= s_data_i;
    end else if (leave) begin
      m1_cyc_o   <= 1'b0;
      m1_stb_o   <= 1'b0;
    end
  end

  // routing selection and watchdog wait counter (counts only while in REQ)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q    <= 1'b0;
      wait_cnt <= '0;
    end else if (accept) begin
      sel_q    <= dec_sel;
      wait_cnt <= '0;
    end else if ((state_q == REQ) && !leave) begin
      wait_cnt <= wait_cnt + 32'd1;
    end
  end

  // core response: one-cycle ack/err pulse, read data capture, expiry count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ack_o         <= 1'b0;
      s_err_o         <= 1'b0;
      s_data_o        <= '0;
      timeout_count_o <= '0;
    end else begin
      s_ack_o <= ack_hit | expire;
      s_err_o <= expire;
      if (ack_hit) begin
        s_data_o <= sel_q ? m1_data_i : m0_data_i;
      end else if (expire) begin
        s_data_o <= '0;
        if (timeout_count_o != '1) begin
          timeout_count_o <= timeout_count_o + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_mem_router.sv
// Testbench for wb_mem_router: table of directed transactions, hand-written
// multi-cycle sequences (turnaround, abort, reset mid-request) and random
// transactions checked against a transaction-level reference model.
module tb_wb_mem_router;

  localparam int T_OUT = 8;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] MASK = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic        s_ack, s_err;
  logic        m0_cyc, m0_stb, m0_we, m0_ack;
  logic [3:0]  m0_wstrb;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_cyc, m1_stb, m1_we, m1_ack;
  logic [3:0]  m1_wstrb;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [15:0] tcount;

  int errors = 0;
  int checks = 0;

  wb_mem_router #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .DATA_MEM_BASE (BASE),
    .DATA_MEM_MASK (MASK),
    .TIMEOUT_CYCLES(T_OUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_cyc_i        (s_cyc),
    .s_stb_i        (s_stb),
    .s_we_i         (s_we),
    .s_wstrb_i      (s_wstrb),
    .s_addr_i       (s_addr),
    .s_data_i       (s_wdata),
    .s_data_o       (s_rdata),
    .s_ack_o        (s_ack),
    .s_err_o        (s_err),
    .m0_cyc_o       (m0_cyc),
    .m0_stb_o       (m0_stb),
    .m0_we_o        (m0_we),
    .m0_wstrb_o     (m0_wstrb),
    .m0_addr_o      (m0_addr),
    .m0_data_o      (m0_wdata),
    .m0_data_i      (m0_rdata),
    .m0_ack_i       (m0_ack),
    .m1_cyc_o       (m1_cyc),
    .m1_stb_o       (m1_stb),
    .m1_we_o        (m1_we),
    .m1_wstrb_o     (m1_wstrb),
    .m1_addr_o      (m1_addr),
    .m1_data_o      (m1_wdata),
    .m1_data_i      (m1_rdata),
    .m1_ack_i       (m1_ack),
    .timeout_count_o(tcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          k;          // REQ cycle carrying the ack, 0 = never
    logic [31:0] rdata;
    logic        stray;      // ack the other port every cycle
    logic        port;
    int          exp_ack_at;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_pay;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[10];

  // transaction results
  int          ack_at, pay_cyc, other_cyc;
  logic [31:0] rd;
  logic        rerr, pulse_ok;
  logic [15:0] model_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drives one core transaction starting at a negedge and plays the
  // downstream slave on the given port. Returns the cycle (1 = first REQ
  // cycle) in which s_ack was seen, response, payload cycles, and whether
  // the ack pulse was single-cycle with both ports idle afterwards.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int k, input logic [31:0] rdata,
                         input logic stray, input logic port);
    logic m;
    s_cyc = 1'b1; s_stb = 1'b1; s_we = we;
    s_addr = addr; s_wdata = wdata; s_wstrb = wstrb;
    ack_at = 0; rd = '0; rerr = 1'b0; pay_cyc = 0; other_cyc = 0;
    @(negedge clk);
    for (int j = 1; j <= 40 && ack_at == 0; j++) begin
      if (s_ack) begin
        ack_at = j;
        rd     = s_rdata;
        rerr   = s_err;
      end else begin
        if (port) begin
          m = m1_cyc && m1_stb && (m1_we == we) && (m1_wstrb == wstrb) &&
              (m1_addr == addr) && (m1_wdata == wdata);
          if (m0_cyc || m0_stb) other_cyc++;
          m1_ack = (j == k); m1_rdata = rdata;
          m0_ack = stray;    m0_rdata = ~rdata;
        end else begin
          m = m0_cyc && m0_stb && (m0_we == we) && (m0_wstrb == wstrb) &&
              (m0_addr == addr) && (m0_wdata == wdata);
          if (m1_cyc || m1_stb) other_cyc++;
          m0_ack = (j == k); m0_rdata = rdata;
          m1_ack = stray;    m1_rdata = ~rdata;
        end
        if (m) pay_cyc++;
        @(negedge clk);
        m0_ack = 1'b0;
        m1_ack = 1'b0;
      end
    end
    s_cyc = 1'b0;
    s_stb = 1'b0;
    @(negedge clk);
    pulse_ok = !s_ack && !m0_cyc && !m1_cyc;
  endtask

  task automatic check_txn(input string tag, input int exp_ack_at, input logic [31:0] exp_data,
                           input logic exp_err, input int exp_pay, input logic [15:0] exp_cnt);
    check({tag, ".ack_latency"}, ack_at, exp_ack_at);
    check({tag, ".data"}, rd, exp_data);
    check({tag, ".err"}, rerr, exp_err);
    check({tag, ".payload_cycles"}, pay_cyc, exp_pay);
    check({tag, ".other_port_busy"}, other_cyc, 0);
    check({tag, ".single_ack"}, pulse_ok, 1'b1);
    check({tag, ".timeout_count"}, tcount, exp_cnt);
  endtask

  initial begin
    logic [6:0]  cyc_bits, ack_bits;
    int          hi;
    logic        saw_ack;
    logic        we, port, stray;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  wstrb;
    int          k;

    //              we    addr           wdata          wstrb    k  rdata          stray port ack data           err  pay cnt
    vecs[0] = '{1'b0, 32'h0000_0100, 32'h0000_0000, 4'b1111, 1, 32'h1234_5678, 1'b0, 1'b0, 2, 32'h1234_5678, 1'b0, 1, 16'd0};
    vecs[1] = '{1'b1, 32'h8000_0040, 32'hCAFE_F00D, 4'b0011, 5, 32'h1111_2222, 1'b0, 1'b1, 6, 32'h1111_2222, 1'b0, 5, 16'd0};
    vecs[2] = '{1'b0, 32'h0000_2000, 32'h0000_0000, 4'b1111, 0, 32'hFFFF_FFFF, 1'b0, 1'b0, 9, 32'h0000_0000, 1'b1, 8, 16'd1};
    vecs[3] = '{1'b0, 32'h0000_2004, 32'h0000_0000, 4'b1111, 0, 32'hFFFF_FFFF, 1'b0, 1'b0, 9, 32'h0000_0000, 1'b1, 8, 16'd2};
    vecs[4] = '{1'b0, 32'h0000_2008, 32'h0000_0000, 4'b1111, 0, 32'hFFFF_FFFF, 1'b0, 1'b0, 9, 32'h0000_0000, 1'b1, 8, 16'd3};
    vecs[5] = '{1'b0, 32'h0000_200C, 32'h0000_0000, 4'b1111, 0, 32'hFFFF_FFFF, 1'b0, 1'b0, 9, 32'h0000_0000, 1'b1, 8, 16'd4};
    vecs[6] = '{1'b0, 32'hFFFF_0000, 32'h0000_0000, 4'b1111, 8, 32'hA5A5_5A5A, 1'b0, 1'b1, 9, 32'hA5A5_5A5A, 1'b0, 8, 16'd4};
    vecs[7] = '{1'b0, 32'h0000_0300, 32'h0000_0000, 4'b1111, 3, 32'h0BAD_F00D, 1'b1, 1'b0, 4, 32'h0BAD_F00D, 1'b0, 3, 16'd4};
    vecs[8] = '{1'b1, 32'h7FFF_FFFC, 32'h1357_9BDF, 4'b1000, 2, 32'h2468_ACE0, 1'b0, 1'b0, 3, 32'h2468_ACE0, 1'b0, 2, 16'd4};
    vecs[9] = '{1'b1, 32'h8000_0000, 32'h0F0F_0F0F, 4'b0100, 1, 32'h9ABC_DEF0, 1'b0, 1'b1, 2, 32'h9ABC_DEF0, 1'b0, 1, 16'd4};

    rst = 1'b1;
    s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
    s_wstrb = '0; s_addr = '0; s_wdata = '0;
    m0_ack = 1'b0; m1_ack = 1'b0; m0_rdata = '0; m1_rdata = '0;
    @(negedge clk);
    @(negedge clk);

    // reset values
    check("reset.m0", {m0_cyc, m0_stb, m0_we, m0_wstrb, m0_addr, m0_wdata}, '0);
    check("reset.m1", {m1_cyc, m1_stb, m1_we, m1_wstrb, m1_addr, m1_wdata}, '0);
    check("reset.resp", {s_ack, s_err, s_rdata}, '0);
    check("reset.timeout_count", tcount, 16'd0);
    rst = 1'b0;
    @(negedge clk);

    // directed table
    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
              vecs[i].k, vecs[i].rdata, vecs[i].stray, vecs[i].port);
      check_txn($sformatf("vec%0d", i), vecs[i].exp_ack_at, vecs[i].exp_data,
                vecs[i].exp_err, vecs[i].exp_pay, vecs[i].exp_cnt);
    end
    model_cnt = 16'd4;

    // request held high with ack held high: best-case 3-cycle turnaround,
    // acks in RESP/IDLE ignored, no acceptance during RESP
    s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0; s_addr = 32'h0000_0040;
    m0_ack = 1'b1; m0_rdata = 32'h0000_0077;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      cyc_bits[6-i] = m0_cyc;
      ack_bits[6-i] = s_ack;
    end
    check("b2b.m0_cyc_pattern", cyc_bits, 7'b1001001);
    check("b2b.ack_pattern", ack_bits, 7'b0100100);
    check("b2b.data", s_rdata, 32'h0000_0077);
    s_cyc = 1'b0; s_stb = 1'b0; m0_ack = 1'b0;
    repeat (3) @(negedge clk);

    // abort on the 3rd REQ cycle, with a stray port-1 ack in that cycle
    s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0; s_addr = 32'h0000_0500;
    hi = 0;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      if (m0_cyc && m0_stb) hi++;
      if (j == 3) begin
        s_cyc = 1'b0; s_stb = 1'b0; m1_ack = 1'b1;
      end
    end
    check("abort.cyc_cycles", hi, 3);
    @(negedge clk);
    m1_ack = 1'b0;
    check("abort.m0_dropped", {m0_cyc, m0_stb}, 2'b00);
    saw_ack = s_ack;
    repeat (4) begin
      @(negedge clk);
      saw_ack = saw_ack | s_ack;
    end
    check("abort.no_ack", saw_ack, 1'b0);
    check("abort.timeout_count", tcount, model_cnt);

    // random transactions against a transaction-level model
    for (int i = 0; i < 60; i++) begin
      we    = 1'($urandom_range(0, 1));
      addr  = $urandom;
      wdata = $urandom;
      wstrb = 4'($urandom_range(0, 15));
      k     = $urandom_range(0, 10);
      rdata = $urandom;
      stray = 1'($urandom_range(0, 1));
      port  = ((addr & MASK) == BASE);
      run_txn(we, addr, wdata, wstrb, k, rdata, stray, port);
      if (k >= 1 && k <= T_OUT) begin
        check_txn($sformatf("rnd%0d", i), k + 1, rdata, 1'b0, k, model_cnt);
      end else begin
        if (model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
        check_txn($sformatf("rnd%0d", i), T_OUT + 1, 32'h0, 1'b1, T_OUT, model_cnt);
      end
    end

    // reset asserted between clock edges while port 1 is busy
    s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1; s_addr = 32'h8000_1000;
    s_wdata = 32'hDEAD_BEEF; s_wstrb = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    check("rstmid.m1_busy", m1_cyc, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("rstmid.m0", {m0_cyc, m0_stb, m0_we, m0_wstrb, m0_addr, m0_wdata}, '0);
    check("rstmid.m1", {m1_cyc, m1_stb, m1_we, m1_wstrb, m1_addr, m1_wdata}, '0);
    check("rstmid.resp", {s_ack, s_err, s_rdata}, '0);
    check("rstmid.timeout_count", tcount, 16'd0);
    s_cyc = 1'b0; s_stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_cnt = 16'd0;
    @(negedge clk);
    run_txn(1'b0, 32'h0000_0010, 32'h0, 4'b1111, 2, 32'h5555_AAAA, 1'b0, 1'b0);
    check_txn("post_reset", 3, 32'h5555_AAAA, 1'b0, 2, model_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
